// File: rtl/survivor_tb_213_pkg.sv
// survivor_tb_213_pkg
//   Shared trellis definitions for the K=3 / rate-1/2 Viterbi datapath
//   (ACS array and survivor traceback): path-metric width, constraint
//   parameters, the traceback FSM encoding and the predecessor rule.
//   No ports.
package survivor_tb_213_pkg;

    localparam int PM_W       = 4;   // path-metric width (ACS acs_ppm_out)
    localparam int K          = 1;   // information bits per trellis step
    localparam int NUM_STATES = 4;
    localparam int ST_W       = 2;   // log2(NUM_STATES)

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        TRACE = 2'd1,
        DRAIN = 2'd2
    } tb_state_e;

    // State s = {newest bit, previous bit}; its predecessor shifts the older
    // bit up and takes the survivor decision b as the bit that fell off.
    function automatic logic [ST_W-1:0] pred_state(input logic [ST_W-1:0] s,
                                                   input logic            b);
        return {s[0], b};
    endfunction

endpackage

// File: rtl/survivor_tb_213_min4.sv
// pm_min4_213
//   Combinational 4-way unsigned minimum over the packed path metrics.
//   Ties resolve to the lowest state index.
//   Ports:
//     pm_bus  [4*W-1:0]  in   metric of state i at [i*W +: W]
//     min_idx [1:0]      out  index of the smallest metric
module pm_min4_213
    import survivor_tb_213_pkg::*;
#(
    parameter int W = PM_W
) (
    input  logic [4*W-1:0] pm_bus,
    output logic [1:0]     min_idx
);

    logic [W-1:0] pm0, pm1, pm2, pm3;
    logic [W-1:0] lo_pm, hi_pm;
    logic [1:0]   lo_idx, hi_idx;

    assign pm0 = pm_bus[0*W +: W];
    assign pm1 = pm_bus[1*W +: W];
    assign pm2 = pm_bus[2*W +: W];
    assign pm3 = pm_bus[3*W +: W];

    // Strict '<' everywhere so that an equal metric never displaces the
    // lower-indexed candidate.
    always_comb begin
        lo_idx = 2'd0;
        lo_pm  = pm0;
        if (pm1 < pm0) begin
            lo_idx = 2'd1;
            lo_pm  = pm1;
        end
        hi_idx = 2'd2;
        hi_pm  = pm2;
        if (pm3 < pm2) begin
            hi_idx = 2'd3;
            hi_pm  = pm3;
        end
        min_idx = (hi_pm < lo_pm) ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/survivor_tb_213.sv
// survivor_tb_213
//   Survivor memory and traceback for a 4-state Viterbi decoder. Collects
//   TB_DEPTH decision columns (FILL), traces back from the start state
//   (TRACE, TB_DEPTH cycles), then streams the decoded bits oldest first
//   with valid/ready handshake (DRAIN).
//   Build option: define TB_ZERO_TAIL_EN for zero-terminated frames -- the
//   traceback then always starts at state 0 and pm_bus is ignored.
//   Ports:
//     clock, reset            rising-edge clock, async active-high reset
//     dec_valid/dec_ready     decision column handshake
//     dec_bits [3:0]          bit i = survivor decision of state i
//     pm_bus [4*W-1:0]        path metrics, state i at [i*W +: W]
//     out_bit/out_valid/out_ready  decoded bit stream
//     best_state [1:0]        traceback start state of current frame
//     frame_done              one-cycle pulse after the last bit is taken
module survivor_tb_213
    import survivor_tb_213_pkg::*;
#(
    parameter int W        = PM_W,
    parameter int TB_DEPTH = 16
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           dec_valid,
    output logic           dec_ready,
    input  logic [3:0]     dec_bits,
    input  logic [4*W-1:0] pm_bus,
    output logic           out_bit,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [1:0]     best_state,
    output logic           frame_done
);

    localparam int PW = $clog2(TB_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(TB_DEPTH - 1);

    tb_state_e            state_q, state_d;
    // ptr_q: write pointer in FILL, (column + 1) in TRACE, read pointer in
    // DRAIN. Every phase leaves it at 0, so one counter serves all three.
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [ST_W-1:0]      s_q, s_d;
    logic [1:0]           best_q, best_d;
    logic                 out_valid_q, out_valid_d;
    logic                 frame_done_q, frame_done_d;
    logic                 dec_ready_q, dec_ready_d;
    logic [TB_DEPTH-1:0]  u_q, u_d;

    logic [NUM_STATES-1:0] surv_q [TB_DEPTH];
    logic                  mem_we;
    logic [PW-1:0]         trace_col;
    logic [1:0]            start_state;
    logic                  accept;

`ifdef TB_ZERO_TAIL_EN
    logic unused_pm;
    assign unused_pm   = ^pm_bus;
    assign start_state = 2'd0;
`else
    pm_min4_213 #(.W(W)) u_min (
        .pm_bus  (pm_bus),
        .min_idx (start_state)
    );
`endif

    assign accept    = dec_valid & dec_ready_q;
    assign trace_col = ptr_q - PW'(1);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        s_d          = s_q;
        best_d       = best_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;
        u_d          = u_q;
        mem_we       = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + PW'(1);  // wraps to 0 after the last column
                    if (ptr_q == LAST) begin
                        state_d = TRACE;
                        best_d  = start_state;
                        s_d     = start_state;
                    end
                end
            end
            TRACE: begin
                u_d[trace_col] = s_q[1];
                s_d            = pred_state(s_q, surv_q[trace_col][s_q]);
                ptr_d          = trace_col;
                if (trace_col == '0)
                    state_d = DRAIN;
            end
            DRAIN: begin
                // First DRAIN cycle only raises valid; bits then advance on
                // each handshake.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    ptr_d = ptr_q + PW'(1);
                    if (ptr_q == LAST) begin
                        out_valid_d  = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase
        dec_ready_d = (state_d == FILL);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= FILL;
            ptr_q        <= '0;
            s_q          <= '0;
            best_q       <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            dec_ready_q  <= 1'b0;
            u_q          <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            s_q          <= s_d;
            best_q       <= best_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            dec_ready_q  <= dec_ready_d;
            u_q          <= u_d;
        end
    end

    // Survivor columns are fully rewritten each frame, so no reset.
    always_ff @(posedge clock) begin
        if (mem_we)
            surv_q[ptr_q] <= dec_bits;
    end

    assign dec_ready  = dec_ready_q;
    assign out_valid  = out_valid_q;
    assign out_bit    = out_valid_q & u_q[ptr_q];
    assign best_state = best_q;
    assign frame_done = frame_done_q;

endmodule
